adder_scheduler: RTL and testbench
==================================

# adder_scheduler

Shares one `adder` instance between `REQUESTERS` independent operand sources. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, round-robin. It drives the granted operands into the adder, waits out the adder's fixed latency, and returns sum, overflow and requester id on a response handshake. It sits between the requester-side logic (counters or other producers) and the shared adder in the top level.

## Interface
Parameters:
- `WIDTH`, 32, operand/sum width; must match the attached adder.
- `REQUESTERS`, 4, number of requesters; at least 2.
- `ADD_LATENCY`, 1, cycles from adder operand change to valid `o_sum`; at least 1.
- `IDW`, `$clog2(REQUESTERS)`, derived id width; not overridden.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_req_valid`  in  `[REQUESTERS]`  per-requester operand valid.
- `o_req_ready`  out  `[REQUESTERS]`  per-requester accept; one-hot or zero.
- `i_req_a`, `i_req_b`  in  `[REQUESTERS][WIDTH]`  per-requester operands.
- `o_add_a`, `o_add_b`  out  `WIDTH`  registered operands to the adder.
- `i_add_sum`  in  `WIDTH`  adder sum.
- `i_add_overflow`  in  1  adder overflow.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response accept.
- `o_rsp_id`  out  `IDW`  requester index of the response.
- `o_rsp_sum`  out  `WIDTH`  captured sum.
- `o_rsp_overflow`  out  1  captured overflow.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. Exactly one operation is in flight at a time.
- **IDLE**
  - If any `i_req_valid` is high, the round-robin arbiter picks grant `g`.
  - Search order starts at `last_grant+1` and wraps modulo `REQUESTERS`.
  - `o_req_ready[g]` is driven high combinationally in this cycle only. All other ready bits are 0. Ready is 0 in every other state.
  - On the handshake edge:
    - `o_add_a`/`o_add_b` load `i_req_a[g]`/`i_req_b[g]`.
    - The id register loads `g` and `last_grant` loads `g`.
    - The wait counter loads `ADD_LATENCY`; next state is WAIT.
- **WAIT**
  - If counter==0: capture `i_add_sum`/`i_add_overflow` into the response registers; next state is RESP.
  - Otherwise: decrement the counter.
- **RESP**
  - `o_rsp_valid`=1. Id, sum and overflow are held stable until `i_rsp_ready`.
  - On the handshake edge: next state is IDLE.
  - No new grant is made in the RESP cycle, even if requests are pending.
- `o_add_a`/`o_add_b` hold the last issued operands between operations.
- Requester rule: once valid is asserted, `i_req_valid` and the operands are held until ready. The block samples operands only on the handshake edge.
- Fairness: a continuously requesting requester is granted within `REQUESTERS` operations.
- Overflow and sum are passed through unchanged from the adder. The block does no arithmetic.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - State IDLE; counter 0; `last_grant`=`REQUESTERS-1`, so requester 0 wins first.
  - `o_add_a`, `o_add_b`, `o_rsp_sum`, `o_rsp_id`, `o_rsp_overflow` are 0.
  - `o_rsp_valid`, `o_busy`, `o_req_ready` are 0.
- Latency: request handshake in cycle T leads to `o_rsp_valid` high from cycle T+`ADD_LATENCY`+2.
- Minimum issue spacing is `ADD_LATENCY`+3 cycles, reached when `i_rsp_ready` is tied high.
- Simultaneous requests in IDLE: exactly one is granted; the others keep waiting with ready=0.
- A requester that raises valid in WAIT or RESP is considered at the next IDLE cycle.
- Reset mid-operation: the in-flight operation and any pending response are discarded. The adder must receive the same reset event.

## Structure
- Package `adder_sched_pkg` holds:
  - the state enum typedef (IDLE/WAIT/RESP);
  - an id-width helper function (returns 1 when `REQUESTERS`=2).
- Sub-module `rr_arbiter`, parameterised by `REQUESTERS`:
  - combinational one-hot grant from the request vector and the pointer;
  - pointer register updated on an `advance` strobe;
  - encoded grant index output.

## Test plan
- **Reset values:** after reset release, all outputs are 0 and the state is IDLE. Assert `i_rst_n`=0 mid-WAIT → `o_busy`=0 and `o_rsp_valid`=0 immediately (async).
- **Single op:** requester 2 sends a=5, b=7 at cycle T, `ADD_LATENCY`=1 → `o_rsp_valid` at T+3 with id=2, sum=12, overflow=0. The response is held until `i_rsp_ready`.
- **Overflow:** WIDTH=32, a=0xFFFF_FFFF, b=1 → sum=0, overflow=1.
- **Round-robin:** all 4 requesters valid continuously with `i_rsp_ready`=1 → grant order 0,1,2,3,0,1. Responses are spaced 4 cycles apart.
- **Backpressure:** `i_rsp_ready`=0 for 10 cycles with requester 1 waiting → `o_req_ready` stays 0 and the response stays stable. Requester 1 is granted in the cycle after the response handshake.
- **Latency parameter:** `ADD_LATENCY`=3 with a latency-3 adder model → response at T+5 with the correct sum.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder scheduler.
//   sched_state_e : scheduler FSM states (idle / waiting on adder / response held)
//   id_width()    : width of a requester index, never less than 1
package adder_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } sched_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : request vector
//   advance     : load the pointer with the current grant
//   grant       : one-hot grant (zero when no request)
//   grant_idx   : encoded grant index
//   grant_valid : at least one request is present
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned IDW        = id_width(REQUESTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQUESTERS-1:0] req,
  input  logic                  advance,
  output logic [REQUESTERS-1:0] grant,
  output logic [IDW-1:0]        grant_idx,
  output logic                  grant_valid
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] cand;

  // Search starts one past the last winner and wraps, so the last winner has
  // the lowest priority.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      cand = IDW'((32'(ptr_q) + k) % REQUESTERS);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Reset to the highest index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDW'(REQUESTERS - 1);
    end else if (advance && grant_valid) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one fixed-latency adder between several requesters, round-robin.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready: per-requester operand handshake (ready one-hot or zero)
//   i_req_a, i_req_b       : per-requester operands
//   o_add_a, o_add_b       : registered operands to the shared adder
//   i_add_sum/overflow     : adder result
//   o_rsp_*                : response handshake carrying id, sum and overflow
//   o_busy                 : high whenever an operation is in flight
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned REQUESTERS  = 4,
  parameter int unsigned ADD_LATENCY = 1,
  parameter int unsigned IDW         = id_width(REQUESTERS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [REQUESTERS-1:0]            i_req_valid,
  output logic [REQUESTERS-1:0]            o_req_ready,
  input  logic [REQUESTERS-1:0][WIDTH-1:0] i_req_a,
  input  logic [REQUESTERS-1:0][WIDTH-1:0] i_req_b,
  output logic [WIDTH-1:0]                 o_add_a,
  output logic [WIDTH-1:0]                 o_add_b,
  input  logic [WIDTH-1:0]                 i_add_sum,
  input  logic                             i_add_overflow,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic [IDW-1:0]                   o_rsp_id,
  output logic [WIDTH-1:0]                 o_rsp_sum,
  output logic                             o_rsp_overflow,
  output logic                             o_busy
);

  localparam int unsigned CW = $clog2(ADD_LATENCY + 1);

  sched_state_e          state_q;
  logic [CW-1:0]         cnt_q;
  logic [WIDTH-1:0]      add_a_q, add_b_q, rsp_sum_q;
  logic [IDW-1:0]        rsp_id_q;
  logic                  rsp_valid_q, rsp_ovf_q, busy_q;

  logic                  idle;
  logic [REQUESTERS-1:0] arb_req;
  logic [REQUESTERS-1:0] grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_valid;

  assign idle = (state_q == StIdle);
  // Masking requests outside IDLE keeps ready at zero in WAIT and RESP.
  assign arb_req = idle ? i_req_valid : '0;

  rr_arbiter #(
    .REQUESTERS (REQUESTERS),
    .IDW        (IDW)
  ) u_arb (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .req         (arb_req),
    .advance     (idle),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign o_req_ready    = grant;
  assign o_add_a        = add_a_q;
  assign o_add_b        = add_b_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_id       = rsp_id_q;
  assign o_rsp_sum      = rsp_sum_q;
  assign o_rsp_overflow = rsp_ovf_q;
  assign o_busy         = busy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            add_a_q  <= i_req_a[grant_idx];
            add_b_q  <= i_req_b[grant_idx];
            rsp_id_q <= grant_idx;
            cnt_q    <= CW'(ADD_LATENCY);
            busy_q   <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          // Counter reaches zero exactly when the adder output reflects the
          // operands issued on the grant edge.
          if (cnt_q == '0) begin
            rsp_sum_q   <= i_add_sum;
            rsp_ovf_q   <= i_add_overflow;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_scheduler.sv
module tb_adder_scheduler;

  localparam int W = 32;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 0: latency-1 adder
  logic [R-1:0]        req_valid0, req_ready0;
  logic [R-1:0][W-1:0] req_a0, req_b0;
  logic [W-1:0]        add_a0, add_b0, add_sum0, rsp_sum0;
  logic                add_ovf0, rsp_valid0, rsp_ready0, rsp_ovf0, busy0;
  logic [1:0]          rsp_id0;

  // DUT 1: latency-3 adder
  logic [R-1:0]        req_valid1, req_ready1;
  logic [R-1:0][W-1:0] req_a1, req_b1;
  logic [W-1:0]        add_a1, add_b1, add_sum1, rsp_sum1;
  logic                add_ovf1, rsp_valid1, rsp_ready1, rsp_ovf1, busy1;
  logic [1:0]          rsp_id1;

  adder_scheduler #(.WIDTH(W), .REQUESTERS(R), .ADD_LATENCY(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid0), .o_req_ready(req_ready0),
    .i_req_a(req_a0), .i_req_b(req_b0),
    .o_add_a(add_a0), .o_add_b(add_b0),
    .i_add_sum(add_sum0), .i_add_overflow(add_ovf0),
    .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
    .o_rsp_id(rsp_id0), .o_rsp_sum(rsp_sum0), .o_rsp_overflow(rsp_ovf0),
    .o_busy(busy0)
  );

  adder_scheduler #(.WIDTH(W), .REQUESTERS(R), .ADD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid1), .o_req_ready(req_ready1),
    .i_req_a(req_a1), .i_req_b(req_b1),
    .o_add_a(add_a1), .o_add_b(add_b1),
    .i_add_sum(add_sum1), .i_add_overflow(add_ovf1),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1),
    .o_rsp_id(rsp_id1), .o_rsp_sum(rsp_sum1), .o_rsp_overflow(rsp_ovf1),
    .o_busy(busy1)
  );

  // Pipelined adder models: result appears ADD_LATENCY edges after operands change.
  logic [W:0] pipe0;
  logic [W:0] pipe1 [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe0 <= '0;
    else        pipe0 <= {1'b0, add_a0} + {1'b0, add_b0};
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1[0] <= '0; pipe1[1] <= '0; pipe1[2] <= '0;
    end else begin
      pipe1[0] <= {1'b0, add_a1} + {1'b0, add_b1};
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
    end
  end
  assign add_sum0 = pipe0[W-1:0];
  assign add_ovf0 = pipe0[W];
  assign add_sum1 = pipe1[2][W-1:0];
  assign add_ovf1 = pipe1[2][W];

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid0 = '0; req_a0 = '0; req_b0 = '0; rsp_ready0 = 1'b0;
    req_valid1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation on DUT 0 with response ready tied high. lat counts cycles
  // from the grant cycle to the first cycle with rsp_valid.
  task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [1:0] id, output logic [W-1:0] sum,
                       output logic ovf, output bit ok);
    int n;
    ok = 1'b1; lat = -1; id = '0; sum = '0; ovf = 1'b0;
    @(posedge clk); #1;
    req_a0[idx] = a; req_b0[idx] = b; req_valid0[idx] = 1'b1; rsp_ready0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready0[idx] && n < 40);
    if (!req_ready0[idx]) begin
      ok = 1'b0; req_valid0[idx] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid0[idx] = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid0 && n < 40) begin @(negedge clk); n++; end
    if (!rsp_valid0) begin ok = 1'b0; return; end
    lat = n; id = rsp_id0; sum = rsp_sum0; ovf = rsp_ovf0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid0); end
    total++; if (req_ready0 !== 4'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready0); end
    total++; if ({add_a0, add_b0} !== 64'h0) begin bad++; $display("FAIL reset_add_ops: got %h want 0", {add_a0, add_b0}); end
    total++; if ({rsp_id0, rsp_sum0, rsp_ovf0} !== 35'h0) begin
      bad++; $display("FAIL reset_rsp_regs: got %h want 0", {rsp_id0, rsp_sum0, rsp_ovf0});
    end
    total++; if ({busy1, rsp_valid1, req_ready1} !== 6'h0) begin
      bad++; $display("FAIL reset_dut3: got %b want 0", {busy1, rsp_valid1, req_ready1});
    end
  endtask

  task automatic test_single_op();
    @(posedge clk); #1;
    req_a0[2] = 32'd5; req_b0[2] = 32'd7; req_valid0 = 4'b0100; rsp_ready0 = 1'b0;
    @(negedge clk);
    total++; if (req_ready0 !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready0); end
    @(posedge clk); #1;
    req_valid0 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid0 !== 1'(k >= 3)) begin
        bad++; $display("FAIL single_rsp_valid_T+%0d: got %b want %b", k, rsp_valid0, k >= 3);
      end
    end
    total++; if (rsp_id0 !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", rsp_id0); end
    total++; if (rsp_sum0 !== 32'd12) begin bad++; $display("FAIL single_sum: got %0d want 12", rsp_sum0); end
    total++; if (rsp_ovf0 !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", rsp_ovf0); end
    @(posedge clk); #1;
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    @(negedge clk);
    total++; if ({rsp_valid0, busy0} !== 2'b00) begin
      bad++; $display("FAIL single_release: got valid/busy %b want 00", {rsp_valid0, busy0});
    end
  endtask

  task automatic test_overflow();
    int lat; logic [1:0] id; logic [W-1:0] sum; logic ovf; bit ok;
    do_op(0, 32'hFFFF_FFFF, 32'd1, lat, id, sum, ovf, ok);
    total++; if (!ok || sum !== 32'h0 || ovf !== 1'b1 || id !== 2'd0 || lat != 3) begin
      bad++; $display("FAIL overflow_carry: got ok=%0d id=%0d sum=%h ovf=%b lat=%0d want id=0 sum=0 ovf=1 lat=3",
                      ok, id, sum, ovf, lat);
    end
    do_op(1, 32'h8000_0000, 32'h7FFF_FFFF, lat, id, sum, ovf, ok);
    total++; if (!ok || sum !== 32'hFFFF_FFFF || ovf !== 1'b0 || id !== 2'd1) begin
      bad++; $display("FAIL overflow_nocarry: got ok=%0d id=%0d sum=%h ovf=%b want id=1 sum=ffffffff ovf=0",
                      ok, id, sum, ovf);
    end
  endtask

  task automatic test_round_robin();
    logic [W:0] exp_sum [8];
    int ngrant, nrsp, last_rsp, refresh, gi;
    apply_reset();
    @(posedge clk); #1;
    for (int i = 0; i < R; i++) begin req_a0[i] = $urandom(); req_b0[i] = $urandom(); end
    req_valid0 = '1; rsp_ready0 = 1'b1;
    ngrant = 0; nrsp = 0; last_rsp = 0;
    for (int c = 0; c < 60 && nrsp < 6; c++) begin
      @(negedge clk);
      refresh = -1;
      if (req_ready0 != 4'b0) begin
        total++;
        if (req_ready0 !== (4'b0001 << (ngrant % R))) begin
          bad++; $display("FAIL rr_grant_%0d: got %b want %b", ngrant, req_ready0, 4'b0001 << (ngrant % R));
        end
        gi = 0;
        for (int i = 0; i < R; i++) if (req_ready0[i]) gi = i;
        if (ngrant < 8) exp_sum[ngrant] = {1'b0, req_a0[gi]} + {1'b0, req_b0[gi]};
        ngrant++;
        refresh = gi;
      end
      if (rsp_valid0) begin
        total++;
        if (rsp_id0 !== 2'(nrsp % R) || {rsp_ovf0, rsp_sum0} !== exp_sum[nrsp]) begin
          bad++; $display("FAIL rr_rsp_%0d: got id=%0d %h want id=%0d %h", nrsp, rsp_id0,
                          {rsp_ovf0, rsp_sum0}, nrsp % R, exp_sum[nrsp]);
        end
        if (nrsp > 0) begin
          total++;
          if (cyc - last_rsp != 4) begin
            bad++; $display("FAIL rr_spacing_%0d: got %0d want 4", nrsp, cyc - last_rsp);
          end
        end
        last_rsp = cyc;
        nrsp++;
      end
      @(posedge clk); #1;
      if (refresh >= 0) begin req_a0[refresh] = $urandom(); req_b0[refresh] = $urandom(); end
      if (nrsp >= 6) req_valid0 = '0;
    end
    req_valid0 = '0;
    total++; if (nrsp != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", nrsp); end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [W:0] exp0, exp1;
    int n;
    apply_reset();
    @(posedge clk); #1;
    req_a0[0] = $urandom(); req_b0[0] = $urandom(); req_valid0[0] = 1'b1; rsp_ready0 = 1'b0;
    exp0 = {1'b0, req_a0[0]} + {1'b0, req_b0[0]};
    @(negedge clk);
    total++; if (req_ready0 !== 4'b0001) begin bad++; $display("FAIL bp_grant0: got %b want 0001", req_ready0); end
    @(posedge clk); #1;
    req_valid0[0] = 1'b0;
    req_a0[1] = $urandom(); req_b0[1] = $urandom(); req_valid0[1] = 1'b1;
    exp1 = {1'b0, req_a0[1]} + {1'b0, req_b0[1]};
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid0 && n < 20);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (req_ready0 !== 4'b0 || rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd0 || {rsp_ovf0, rsp_sum0} !== exp0) begin
        bad++; $display("FAIL bp_hold_%0d: got rdy=%b v=%b id=%0d %h want rdy=0000 v=1 id=0 %h",
                        k, req_ready0, rsp_valid0, rsp_id0, {rsp_ovf0, rsp_sum0}, exp0);
      end
    end
    @(posedge clk); #1;
    rsp_ready0 = 1'b1;
    @(negedge clk);
    total++; if (req_ready0 !== 4'b0) begin bad++; $display("FAIL bp_no_grant_in_resp: got %b want 0000", req_ready0); end
    @(negedge clk);
    total++; if (req_ready0 !== 4'b0010) begin bad++; $display("FAIL bp_grant1: got %b want 0010", req_ready0); end
    @(posedge clk); #1;
    req_valid0[1] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid0 && n < 20);
    total++; if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd1 || {rsp_ovf0, rsp_sum0} !== exp1) begin
      bad++; $display("FAIL bp_rsp1: got v=%b id=%0d %h want v=1 id=1 %h", rsp_valid0, rsp_id0,
                      {rsp_ovf0, rsp_sum0}, exp1);
    end
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
  endtask

  task automatic test_latency3();
    logic [W:0] expv;
    int n, t0, idx;
    rsp_ready1 = 1'b1;
    for (int op = 0; op < 3; op++) begin
      idx = (op == 0) ? 3 : int'($urandom_range(0, R - 1));
      @(posedge clk); #1;
      req_a1[idx] = $urandom(); req_b1[idx] = $urandom(); req_valid1[idx] = 1'b1;
      expv = {1'b0, req_a1[idx]} + {1'b0, req_b1[idx]};
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready1[idx] && n < 20);
      t0 = cyc;
      @(posedge clk); #1;
      req_valid1[idx] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid1 && n < 20);
      total++;
      if (!rsp_valid1 || cyc - t0 != 5 || rsp_id1 !== 2'(idx) || {rsp_ovf1, rsp_sum1} !== expv) begin
        bad++; $display("FAIL lat3_op%0d: got v=%b lat=%0d id=%0d %h want v=1 lat=5 id=%0d %h", op,
                        rsp_valid1, cyc - t0, rsp_id1, {rsp_ovf1, rsp_sum1}, idx, expv);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    apply_reset();
    @(posedge clk); #1;
    req_a0[2] = $urandom(); req_b0[2] = $urandom(); req_valid0[2] = 1'b1; rsp_ready0 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid0 = '0;
    @(negedge clk);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b want 1", busy0); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy0, rsp_valid0} !== 2'b00) begin
      bad++; $display("FAIL midreset_async: got busy/valid %b want 00", {busy0, rsp_valid0});
    end
    total++; if ({add_a0, add_b0} !== 64'h0) begin bad++; $display("FAIL midreset_ops: got %h want 0", {add_a0, add_b0}); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid0 || busy0) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_discard: got %0d active cycles want 0", seen); end
  endtask

  typedef struct {
    int         id;
    logic [W:0] s;
    int         gc;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int last, granted, want;
    logic [R-1:0] exp_vec;
    bit shown;
    apply_reset();
    last = R - 1; granted = -1; shown = 1'b0;
    for (int c = 0; c < 430; c++) begin
      @(posedge clk); #1;
      if (granted >= 0) req_valid0[granted] = 1'b0;
      if (c < 400) begin
        for (int i = 0; i < R; i++) begin
          if (!req_valid0[i] && $urandom_range(0, 2) == 0) begin
            req_a0[i] = $urandom(); req_b0[i] = $urandom(); req_valid0[i] = 1'b1;
          end
        end
        rsp_ready0 = 1'($urandom_range(0, 1));
      end else begin
        rsp_ready0 = 1'b1;
      end
      @(negedge clk);
      granted = -1;
      // Grant only when nothing is in flight; winner is the first valid
      // requester after the previous winner.
      want = -1;
      if (q.size() == 0) begin
        for (int k = 1; k <= R; k++) begin
          if (want < 0 && req_valid0[(last + k) % R]) want = (last + k) % R;
        end
      end
      exp_vec = (want >= 0) ? (4'b0001 << want) : 4'b0000;
      total++;
      if (req_ready0 !== exp_vec) begin
        bad++; $display("FAIL rand_grant_c%0d: got %b want %b", c, req_ready0, exp_vec);
      end
      if (want >= 0) begin
        e.id = want; e.s = {1'b0, req_a0[want]} + {1'b0, req_b0[want]}; e.gc = cyc;
        q.push_back(e);
        last = want; granted = want;
      end
      if (rsp_valid0) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_rsp_unexpected_c%0d: got valid=1 want 0", c);
        end else if ((!shown && cyc != q[0].gc + 3) || rsp_id0 !== 2'(q[0].id) ||
                     {rsp_ovf0, rsp_sum0} !== q[0].s) begin
          bad++; $display("FAIL rand_rsp_c%0d: got lat=%0d id=%0d %h want lat=3 id=%0d %h", c,
                          cyc - q[0].gc, rsp_id0, {rsp_ovf0, rsp_sum0}, q[0].id, q[0].s);
        end
        if (rsp_ready0 && q.size() != 0) void'(q.pop_front());
      end
      shown = rsp_valid0 && !rsp_ready0;
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", q.size()); end
    req_valid0 = '0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_latency3();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
